// File: rtl/seq_controlpath_if.sv
// Bus of the multi-cycle control sequencer: instruction handshake plus the
// shared-bus control lines it owns (register file, ALU operand latches, imm).
interface seq_controlpath_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    // instr_valid/instr_ready: a word transfers on a rising clk edge where both
    // are high; valid may stay high, ready is high only while the sequencer idles.
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           machine_code;
    logic [2:0]            alu_function_sel;
    logic                  alu_store_1;
    logic                  alu_store_2;
    logic                  alu_broadcast;
    logic [REG_ADDR_W-1:0] register_index;
    logic                  register_read_enable;
    logic                  register_write_enable;
    logic [XLEN-1:0]       imm;
    logic                  imm_en;
    logic                  done;
    logic                  illegal_instr;

    modport master (
        input  instr_valid, machine_code,
        output instr_ready, alu_function_sel, alu_store_1, alu_store_2,
               alu_broadcast, register_index, register_read_enable,
               register_write_enable, imm, imm_en, done, illegal_instr
    );

    modport slave (
        output instr_valid, machine_code,
        input  instr_ready, alu_function_sel, alu_store_1, alu_store_2,
               alu_broadcast, register_index, register_read_enable,
               register_write_enable, imm, imm_en, done, illegal_instr
    );
endinterface

// File: rtl/seq_controlpath.sv
// RV32I R/I-type ALU sequencer: IDLE->DECODE->LOAD_A->LOAD_B->WB->FIN, all bus enables registered.
// Optional macro SEQ_CONTROLPATH_ILLEGAL_TRAP_EN: pulse illegal_instr with done on illegal words.
module seq_controlpath #(
    parameter int XLEN          = 32,
    parameter int REG_ADDR_W    = 5,
    parameter bit SKIP_X0_WRITE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    seq_controlpath_if.master   bus,
    output logic [2:0]          state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        LOAD_A = 3'd2,
        LOAD_B = 3'd3,
        WB     = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    state_t      state;
    logic [31:0] ir;
    logic        is_r;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign rs1       = ir[15 +: REG_ADDR_W];
    assign rs2       = ir[20 +: REG_ADDR_W];
    assign rd        = ir[7 +: REG_ADDR_W];
    assign state_dbg = state;

    // funct3 to ALU select; SUB is the only op not reachable from funct3 alone.
    function automatic logic [2:0] sel_of(input logic [2:0] f3);
        case (f3)
            3'b000:  return 3'd0;
            3'b001:  return 3'd2;
            3'b010:  return 3'd3;
            default: return f3;
        endcase
    endfunction

    logic            dec_legal;
    logic            dec_r;
    logic [2:0]      dec_sel;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_legal = 1'b0;
        dec_r     = 1'b0;
        dec_sel   = 3'd0;
        dec_imm   = '0;
        if (opcode == OP_R) begin
            dec_r = 1'b1;
            if (funct7 == 7'h00 && funct3 != 3'b011) begin
                dec_legal = 1'b1;
                dec_sel   = sel_of(funct3);
            end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                dec_legal = 1'b1;
                dec_sel   = 3'd1;
            end
        end else if (opcode == OP_I) begin
            case (funct3)
                3'b001, 3'b101: begin
                    if (funct7 == 7'h00) begin
                        dec_legal = 1'b1;
                        dec_sel   = sel_of(funct3);
                        dec_imm   = XLEN'(ir[24:20]);
                    end
                end
                3'b011: ;
                default: begin
                    dec_legal = 1'b1;
                    dec_sel   = sel_of(funct3);
                    dec_imm   = {{(XLEN-12){ir[31]}}, ir[31:20]};
                end
            endcase
        end
    end

`ifdef SEQ_CONTROLPATH_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign bus.illegal_instr = illegal_q;
`else
    assign bus.illegal_instr = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            ir                        <= '0;
            is_r                      <= 1'b0;
            bus.instr_ready           <= 1'b1;
            bus.alu_function_sel      <= 3'd0;
            bus.imm                   <= '0;
            bus.alu_store_1           <= 1'b0;
            bus.alu_store_2           <= 1'b0;
            bus.alu_broadcast         <= 1'b0;
            bus.register_index        <= '0;
            bus.register_read_enable  <= 1'b0;
            bus.register_write_enable <= 1'b0;
            bus.imm_en                <= 1'b0;
            bus.done                  <= 1'b0;
`ifdef SEQ_CONTROLPATH_ILLEGAL_TRAP_EN
            illegal_q                 <= 1'b0;
`endif
        end else begin
            // Per-step strobes default low; each state raises only its own.
            bus.alu_store_1           <= 1'b0;
            bus.alu_store_2           <= 1'b0;
            bus.alu_broadcast         <= 1'b0;
            bus.register_index        <= '0;
            bus.register_read_enable  <= 1'b0;
            bus.register_write_enable <= 1'b0;
            bus.imm_en                <= 1'b0;
            bus.done                  <= 1'b0;
`ifdef SEQ_CONTROLPATH_ILLEGAL_TRAP_EN
            illegal_q                 <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        ir              <= bus.machine_code;
                        bus.instr_ready <= 1'b0;
                        state           <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        is_r                     <= dec_r;
                        bus.alu_function_sel     <= dec_sel;
                        bus.imm                  <= dec_imm;
                        bus.register_index       <= rs1;
                        bus.register_read_enable <= 1'b1;
                        bus.alu_store_1          <= 1'b1;
                        state                    <= LOAD_A;
                    end else begin
                        bus.done <= 1'b1;
`ifdef SEQ_CONTROLPATH_ILLEGAL_TRAP_EN
                        illegal_q <= 1'b1;
`endif
                        state    <= FIN;
                    end
                end
                LOAD_A: begin
                    bus.alu_store_2 <= 1'b1;
                    if (is_r) begin
                        bus.register_index       <= rs2;
                        bus.register_read_enable <= 1'b1;
                    end else begin
                        bus.imm_en <= 1'b1;
                    end
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    bus.alu_broadcast         <= 1'b1;
                    bus.register_index        <= rd;
                    bus.register_write_enable <= !(SKIP_X0_WRITE && rd == '0);
                    state                     <= WB;
                end
                WB: begin
                    bus.done <= 1'b1;
                    state    <= FIN;
                end
                FIN: begin
                    bus.instr_ready      <= 1'b1;
                    bus.alu_function_sel <= 3'd0;
                    bus.imm              <= '0;
                    state                <= IDLE;
                end
                default: begin
                    bus.instr_ready <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_controlpath.sv
// Cycle-accurate scoreboard bench for seq_controlpath: every cycle's full output
// vector is predicted from the instruction word and compared at the falling edge.
module tb_seq_controlpath;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int W    = 49;
`ifdef SEQ_CONTROLPATH_ILLEGAL_TRAP_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] state_dbg;

    seq_controlpath_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

    seq_controlpath #(.XLEN(XLEN), .REG_ADDR_W(RW), .SKIP_X0_WRITE(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q[$];
    logic [31:0]   op_q[$];
    int            done_cyc[$];
    int            n_checks  = 0;
    int            n_errors  = 0;
    int            cyc_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic rdy, input logic [2:0] sel,
                                          input logic s1, input logic s2, input logic bc,
                                          input logic [4:0] idx, input logic rd_en,
                                          input logic wr_en, input logic [31:0] imm,
                                          input logic imm_en, input logic dn, input logic il);
        return {rdy, sel, s1, s2, bc, idx, rd_en, wr_en, imm, imm_en, dn, il};
    endfunction

    function automatic logic [W-1:0] observed();
        return pack(bus.instr_ready, bus.alu_function_sel, bus.alu_store_1, bus.alu_store_2,
                    bus.alu_broadcast, bus.register_index, bus.register_read_enable,
                    bus.register_write_enable, bus.imm, bus.imm_en, bus.done,
                    bus.illegal_instr);
    endfunction

    function automatic logic [W-1:0] idle_vec();
        return pack(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] mk_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {imm12, rs1, f3, rd, 7'b0010011};
    endfunction

    // Reference decode written from the instruction tables, mnemonic by mnemonic.
    task automatic ref_decode(input logic [31:0] w, output bit legal, output bit r_type,
                              output logic [2:0] sel, output logic [31:0] imm);
        legal  = 1'b0;
        r_type = 1'b0;
        sel    = 3'd0;
        imm    = 32'd0;
        if (w[6:0] == 7'b0110011) begin
            r_type = 1'b1;
            legal  = 1'b1;
            case ({w[31:25], w[14:12]})
                {7'h00, 3'b000}: sel = 3'd0;   // ADD
                {7'h20, 3'b000}: sel = 3'd1;   // SUB
                {7'h00, 3'b001}: sel = 3'd2;   // SLL
                {7'h00, 3'b010}: sel = 3'd3;   // SLT
                {7'h00, 3'b100}: sel = 3'd4;   // XOR
                {7'h00, 3'b101}: sel = 3'd5;   // SRL
                {7'h00, 3'b110}: sel = 3'd6;   // OR
                {7'h00, 3'b111}: sel = 3'd7;   // AND
                default:         legal = 1'b0;
            endcase
        end else if (w[6:0] == 7'b0010011) begin
            legal = 1'b1;
            imm   = {{20{w[31]}}, w[31:20]};
            case (w[14:12])
                3'b000: sel = 3'd0;   // ADDI
                3'b010: sel = 3'd3;   // SLTI
                3'b100: sel = 3'd4;   // XORI
                3'b110: sel = 3'd6;   // ORI
                3'b111: sel = 3'd7;   // ANDI
                3'b001: begin sel = 3'd2; imm = {27'd0, w[24:20]}; legal = (w[31:25] == 7'd0); end
                3'b101: begin sel = 3'd5; imm = {27'd0, w[24:20]}; legal = (w[31:25] == 7'd0); end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
            sel = 3'd0;
            imm = 32'd0;
        end
    endtask

    // Pushes the expected vectors for the cycles after the handshake cycle.
    task automatic push_trace(input logic [31:0] w);
        bit          legal;
        bit          r_type;
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        ref_decode(w, legal, r_type, sel, imm);
        rs1 = w[19:15];
        rs2 = w[24:20];
        rd  = w[11:7];
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (!legal) begin
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ILL_EN));
        end else begin
            exp_q.push_back(pack(0, sel, 1, 0, 0, rs1, 1, 0, imm, 0, 0, 0));
            if (r_type) exp_q.push_back(pack(0, sel, 0, 1, 0, rs2, 1, 0, imm, 0, 0, 0));
            else        exp_q.push_back(pack(0, sel, 0, 1, 0, 5'd0, 0, 0, imm, 1, 0, 0));
            exp_q.push_back(pack(0, sel, 0, 0, 1, rd, 0, rd != 5'd0, imm, 0, 0, 0));
            exp_q.push_back(pack(0, sel, 0, 0, 0, 5'd0, 0, 0, imm, 0, 1, 0));
        end
    endtask

    // ---------------- driver: consumes op_q, checks every cycle ----------------
    task automatic run(input int gap, input bit noise);
        int          wait_gap = 0;
        int          guard    = 0;
        logic [31:0] cur_w    = 32'd0;
        logic [31:0] w;
        while ((op_q.size() != 0 || exp_q.size() != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
            cyc_count++;
            check("bus_excl", 64'($countones({bus.register_read_enable, bus.imm_en,
                                               bus.alu_broadcast}) <= 1), 64'd1);
            if (bus.done) done_cyc.push_back(cyc_count);
            if (exp_q.size() == 0) begin
                check("idle", 64'(observed()), 64'(idle_vec()));
                if (op_q.size() != 0 && wait_gap == 0) begin
                    w                = op_q.pop_front();
                    cur_w            = w;
                    bus.machine_code = w;
                    bus.instr_valid  = 1'b1;
                    push_trace(w);
                    wait_gap = gap;
                end else begin
                    bus.instr_valid = 1'b0;
                    if (wait_gap > 0) wait_gap--;
                end
            end else begin
                check($sformatf("step_%08h", cur_w), 64'(observed()), 64'(exp_q.pop_front()));
                if (noise && exp_q.size() != 0) begin
                    bus.instr_valid  = 1'b1;
                    bus.machine_code = $urandom;
                end else begin
                    bus.instr_valid = 1'b0;
                end
            end
        end
        if (guard >= 5000) check("run_timeout", 64'(guard), 64'd0);
        bus.instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [6:0]  f7;
        logic [11:0] imm12;
        case ($urandom_range(0, 3))
            0: begin
                f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
                return mk_r(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
            end
            1: begin
                imm12 = 12'($urandom);
                if ($urandom_range(0, 1) == 1) imm12[11:5] = 7'd0;
                return mk_i(imm12, 5'($urandom), 3'($urandom), 5'($urandom));
            end
            2: return mk_r(7'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
            default: return $urandom;
        endcase
    endfunction

    task automatic reset_in_wb();
        @(negedge clk);
        check("rst_pre_idle", 64'(observed()), 64'(idle_vec()));
        bus.machine_code = 32'h002081B3;
        bus.instr_valid  = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wb_state", 64'(state_dbg), 64'd4);
        check("rst_wb_wr_en", 64'(bus.register_write_enable), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_wr_en", 64'(bus.register_write_enable), 64'd0);
        check("rst_async_bcast", 64'(bus.alu_broadcast), 64'd0);
        check("rst_async_ready", 64'(bus.instr_ready), 64'd1);
        check("rst_async_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        check("rst_hold_idle", 64'(observed()), 64'(idle_vec()));
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_idle", 64'(observed()), 64'(idle_vec()));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.instr_valid  = 1'b0;
        bus.machine_code = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'(observed()), 64'(idle_vec()));
        check("reset_state", 64'(state_dbg), 64'd0);
        reset = 1'b0;

        // Directed words from the test plan.
        op_q.push_back(32'h002081B3);   // ADD  x3,x1,x2
        op_q.push_back(32'hFFF30293);   // ADDI x5,x6,-1
        op_q.push_back(32'h40208033);   // SUB  x0,x1,x2
        op_q.push_back(32'h0000707F);   // illegal opcode
        run(2, 1'b0);

        // Every ALU op plus the boundary illegal encodings.
        op_q.push_back(mk_r(7'h00, 5'd4, 5'd7, 3'b001, 5'd9));    // SLL
        op_q.push_back(mk_r(7'h00, 5'd4, 5'd7, 3'b010, 5'd9));    // SLT
        op_q.push_back(mk_r(7'h00, 5'd31, 5'd30, 3'b100, 5'd29)); // XOR
        op_q.push_back(mk_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd3));    // SRL
        op_q.push_back(mk_r(7'h00, 5'd1, 5'd2, 3'b110, 5'd3));    // OR
        op_q.push_back(mk_r(7'h00, 5'd1, 5'd2, 3'b111, 5'd3));    // AND
        op_q.push_back(mk_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd3));    // SLTU (illegal)
        op_q.push_back(mk_r(7'h20, 5'd1, 5'd2, 3'b101, 5'd3));    // SRA (illegal)
        op_q.push_back(mk_i(12'h7FF, 5'd8, 3'b010, 5'd10));       // SLTI
        op_q.push_back(mk_i(12'h800, 5'd8, 3'b100, 5'd10));       // XORI
        op_q.push_back(mk_i(12'h0F0, 5'd8, 3'b110, 5'd0));        // ORI to x0
        op_q.push_back(mk_i(12'hA5A, 5'd8, 3'b111, 5'd11));       // ANDI
        op_q.push_back(mk_i(12'h01F, 5'd8, 3'b001, 5'd12));       // SLLI 31
        op_q.push_back(mk_i(12'h005, 5'd8, 3'b101, 5'd13));       // SRLI 5
        op_q.push_back(mk_i(12'h405, 5'd8, 3'b101, 5'd13));       // SRAI (illegal)
        op_q.push_back(mk_i(12'h001, 5'd8, 3'b011, 5'd13));       // SLTIU (illegal)
        run(1, 1'b0);

        // Randomised words with bus noise while busy.
        for (int i = 0; i < 30; i++) op_q.push_back(rand_word());
        run(1, 1'b1);

        // Valid held high across three instructions: one accept per 6 cycles.
        done_cyc.delete();
        op_q.push_back(32'h002081B3);
        op_q.push_back(32'hFFF30293);
        op_q.push_back(mk_r(7'h00, 5'd5, 5'd6, 3'b111, 5'd7));
        run(0, 1'b1);
        check("b2b_done_count", 64'(done_cyc.size()), 64'd3);
        for (int i = 1; i < done_cyc.size(); i++)
            check("b2b_done_spacing", 64'(done_cyc[i] - done_cyc[i-1]), 64'd6);

        reset_in_wb();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
